// File: rtl/decode_uop_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_uop_queue
//  Description : Fetch-to-decode micro-op queue. Accepts up to IN_W fetched
//                instructions per cycle, cracks two-uop operations into a
//                uop0/uop1 pair, and presents up to OUT_W uops per cycle to
//                decode without ever splitting a pair across issue groups.
//  Revision    : 1.0 - initial release
// ============================================================================

typedef logic [31:0] virt_t;
typedef logic [31:0] uint32_t;

typedef enum logic [4:0] {
    OP_ADDU  = 5'd0,
    OP_SUBU  = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_LW    = 5'd4,
    OP_SW    = 5'd5,
    OP_BEQ   = 5'd6,
    OP_MULT  = 5'd7,
    OP_MULTU = 5'd8,
    OP_DIV   = 5'd9,
    OP_DIVU  = 5'd10,
    OP_MADD  = 5'd11,
    OP_MADDU = 5'd12,
    OP_MSUB  = 5'd13,
    OP_MSUBU = 5'd14,
    OP_MUL   = 5'd15
} operation_t;

typedef struct packed {
    logic       ex;
    logic [4:0] cause;
} exception_t;

module decode_uop_queue #(
    parameter int IN_W     = 2,
    parameter int OUT_W    = 2,
    parameter int DEPTH    = 8,
    parameter int CRACK_EN = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_valid,
    input  virt_t                        in_pc        [IN_W],
    input  uint32_t                      in_inst      [IN_W],
    input  operation_t                   in_operation [IN_W],
    input  exception_t                   in_exception [IN_W],
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_valid,
    output virt_t                        out_pc        [OUT_W],
    output uint32_t                      out_inst      [OUT_W],
    output operation_t                   out_operation [OUT_W],
    output exception_t                   out_exception [OUT_W],
    output logic [OUT_W-1:0]             out_is_inst2,
    input  logic [$clog2(OUT_W+1)-1:0]   out_pop,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    // A uop0 in lane i may issue only if its partner sits in a lane below
    // this limit; with a single output lane the pair issues one uop at a time.
    localparam int PAIR_LIM = (OUT_W > 1) ? OUT_W : 2;
    localparam logic [CNT_W-1:0] C_READY_MAX = CNT_W'(DEPTH - 2 * IN_W);

    // 'paired' marks both halves of a cracked instruction so the issue logic
    // can recognise a uop0 whose partner is not yet in the issue window.
    typedef struct packed {
        virt_t      pc;
        uint32_t    inst;
        operation_t op;
        exception_t exc;
        logic       is_inst2;
        logic       paired;
    } uop_t;

    uop_t             mem_q [DEPTH];
    uop_t             mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             w_push;
    logic [CNT_W-1:0] w_push_cnt;
    logic [IN_W-1:0]  w_crack;
    uop_t             w_lane [OUT_W];

    function automatic logic is_two_uop(input operation_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
    endfunction

    // Excepting instructions are never cracked so the exception travels once.
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_crack
        assign w_crack[gi] = (CRACK_EN != 0) && !in_exception[gi].ex &&
                             is_two_uop(in_operation[gi]);
    end

    assign in_ready = (count_q <= C_READY_MAX);
    assign w_push   = in_ready && (|in_valid);
    assign count    = count_q;

    // Expand the accepted fetch group into uops and write them in lane order at the tail.
    always_comb begin
        logic [PTR_W-1:0] idx;
        mem_d      = mem_q;
        w_push_cnt = '0;
        idx        = tail_q;
        for (int i = 0; i < IN_W; i++) begin
            if (w_push && in_valid[i]) begin
                idx = tail_q + w_push_cnt[PTR_W-1:0];
                mem_d[idx] = '{pc: in_pc[i], inst: in_inst[i], op: in_operation[i],
                               exc: in_exception[i], is_inst2: 1'b0,
                               paired: w_crack[i]};
                if (w_crack[i]) begin
                    mem_d[idx + PTR_W'(1)] = '{pc: in_pc[i], inst: in_inst[i],
                                               op: in_operation[i],
                                               exc: in_exception[i],
                                               is_inst2: 1'b1, paired: 1'b1};
                end
                w_push_cnt = w_push_cnt + (w_crack[i] ? CNT_W'(2) : CNT_W'(1));
            end
        end
    end

    // Next pointer and occupancy; flush discards everything, including this cycle's push/pop.
    always_comb begin
        head_d  = head_q + PTR_W'(out_pop);
        tail_d  = tail_q + w_push_cnt[PTR_W-1:0];
        count_d = count_q + w_push_cnt - CNT_W'(out_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and count registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Uop storage carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Present the head window and hold back a uop0 whose uop1 cannot issue alongside it.
    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            w_lane[i]        = mem_q[head_q + PTR_W'(i)];
            out_pc[i]        = w_lane[i].pc;
            out_inst[i]      = w_lane[i].inst;
            out_operation[i] = w_lane[i].op;
            out_exception[i] = w_lane[i].exc;
            out_is_inst2[i]  = w_lane[i].is_inst2;
            out_valid[i]     = (i < int'(count_q)) &&
                               !(w_lane[i].paired && !w_lane[i].is_inst2 &&
                                 !((i + 1 < int'(count_q)) && (i + 1 < PAIR_LIM)));
        end
    end

endmodule

`default_nettype wire

// File: doc/decode_uop_queue.md
DECODE_UOP_QUEUE -- requirements
Module: decode_uop_queue

Interface
REQ-001 SHALL have parameter IN_W, default 2: fetch lanes accepted per cycle.
REQ-002 SHALL have parameter OUT_W, default 2: uop lanes presented to decode per cycle.
REQ-003 SHALL have parameter DEPTH, default 8: uop entries; power of two, at least 2*IN_W.
REQ-004 SHALL have parameter CRACK_EN, default 1: 1 = split two-uop operations; 0 = every instruction yields one uop.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1: discard all queued uops.
REQ-008 SHALL have port in_valid, input, IN_W: per-lane fetch valid; set lanes contiguous from lane 0.
REQ-009 SHALL have ports in_pc (virt_t), in_inst (uint32_t), in_operation (operation_t) and in_exception (exception_t), input, IN_W each: per-lane fetch payload.
REQ-010 SHALL have port in_ready, output, 1: the whole fetch group is accepted this cycle.
REQ-011 SHALL have port out_valid, output, OUT_W: per-lane uop valid, contiguous from lane 0.
REQ-012 SHALL have ports out_pc, out_inst, out_operation, out_exception and out_is_inst2 (1 bit), output, OUT_W each: per-lane uop payload.
REQ-013 SHALL have port out_pop, input, clog2(OUT_W+1): number of lanes consumed this cycle; never exceeds the popcount of out_valid.
REQ-014 SHALL have port count, output, clog2(DEPTH+1): occupied entries.

Function
REQ-015 SHALL classify two-uop operations as OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU and OP_MUL, when CRACK_EN=1 and in_exception.ex=0.
REQ-016 SHALL expand each two-uop instruction into uop0 (is_inst2=0) followed by uop1 (is_inst2=1), with identical pc, inst, operation and exception.
REQ-017 SHALL emit every other instruction as one uop with is_inst2=0.
REQ-018 SHALL drive in_ready = (DEPTH - count >= 2*IN_W), combinationally from registered count only.
REQ-019 SHALL push on in_ready && |in_valid: expanded uops of valid lanes written in lane order at the tail, in one cycle.
REQ-020 SHALL present entries head..head+OUT_W-1 on lanes 0..OUT_W-1 in program order, with out_valid[i] = (i < count).
REQ-021 SHALL never split a uop pair across issue groups: if lane OUT_W-1 holds uop0, that lane's out_valid SHALL be 0.
REQ-022 SHALL, when lane 0 holds uop0 and count=1, hold out_valid[0] at 0 until uop1 is present.
REQ-023 SHALL advance head by out_pop and tail by the number of pushed uops, modulo DEPTH.
REQ-024 SHALL update count = count + pushed - out_pop, with push and pop in the same cycle allowed.
REQ-025 SHALL, on flush=1, set head, tail and count to 0 next cycle; flush SHALL override simultaneous push and pop.
REQ-026 SHALL present out_* payload combinationally from storage (zero-latency read); push-to-visible latency SHALL be 1 cycle.
REQ-027 SHALL register uop storage without reset; only pointers and count are reset.

Reset
REQ-028 SHALL, with resetn=0 at a clock edge, set head=0, tail=0 and count=0, giving out_valid=0 and in_ready=1 the following cycle.
REQ-029 SHALL give reset priority over flush, push and pop, and SHALL discard any in-flight group.

Verification
REQ-030 Push lanes {ADDU pc=0x100, MADD pc=0x104} -> next cycle count=3; lanes show ADDU(is_inst2=0), MADD(is_inst2=0) with out_valid=2'b01 (pair-split rule); after out_pop=1, lanes show MADD/0 and MADD/1 with out_valid=2'b11.
REQ-031 Fill to count=5 with DEPTH=8, IN_W=2 -> in_ready=0; pop 1 -> in_ready=1 next cycle.
REQ-032 Push MUL with in_exception.ex=1 -> a single uop, is_inst2=0, count increments by 1.
REQ-033 Push plus out_pop=2 plus flush in the same cycle -> count=0 and out_valid=0 next cycle.
REQ-034 Stream 20 alternating ADDU/DIV instructions with random out_pop -> output order matches a reference model across pointer wrap; no pair is ever split.
REQ-035 Assert resetn=0 with count=6 -> next cycle count=0, in_ready=1, out_valid=0.
